wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage directly upstream of the integer register file; produces its registered write port (we/waddr/wdata).
- Merges a single-cycle ALU result stream, which has priority, with a backpressured load-result stream.
- Load results get byte/half extraction and are buffered in a small FIFO while the ALU owns the port.
- Keeps a per-register pending-load scoreboard for the issue stage.

Parameters:
XLEN, 32, datapath width; load extension fills to XLEN (only 32 supported for extraction)
DEPTH, 2, load-result FIFO entries; power of two, >=2

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  asynchronous active-low reset
alu_valid_i  input  1  ALU result valid this cycle; no backpressure
alu_rd_i  input  5  ALU destination register
alu_data_i  input  XLEN  ALU result
lsu_valid_i  input  1  load result offered
lsu_ready_o  output  1  load result accepted when valid&&ready
lsu_rd_i  input  5  load destination register
lsu_data_i  input  32  raw aligned memory word
lsu_funct3_i  input  3  load type (RV32I funct3)
lsu_byteoff_i  input  2  address[1:0] of load
pend_set_i  input  1  mark pend_rd_i as awaiting a load
pend_rd_i  input  5  register to mark pending
pending_o  output  32  scoreboard; bit i=1 means load to xi outstanding
rf_we_o  output  1  register-file write enable (registered)
rf_waddr_o  output  5  register-file write address (registered)
rf_wdata_o  output  XLEN  register-file write data (registered)

Behaviour:
- Reset (async, rst_ni=0): rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, FIFO emptied (pending entries discarded), pending_o=0. lsu_ready_o=1 whenever count<DEPTH, so it reads 1 during and after reset.
- lsu_ready_o = (count < DEPTH); based on the registered count only, with no same-cycle pop lookahead.
- Load accept: on valid&&ready the extracted value and rd are pushed at that edge.
- Extraction for LB/LH/LW/LBU/LHU (funct3 000/001/010/100/101):
  - Byte lane = byteoff.
  - Half lane = byteoff[1]; byteoff[0] is ignored.
  - Signed types sign-extend; U types zero-extend.
  - Any other funct3 passes the raw word.
- Output select, evaluated every cycle:
  - alu_valid_i -> ALU result.
  - Else FIFO non-empty -> pop head.
  - Else no write.
  - Selection is registered into rf_*_o at the next edge.
  - Latency: ALU valid in cycle N -> rf_we_o in cycle N+1. Load accepted in cycle N -> earliest rf_we_o in cycle N+2.
  - Every ALU-valid cycle delays FIFO drain by one cycle.
- Ordering: FIFO strictly in order; no load overtakes another.
- Push and pop in the same cycle are both legal; count is unchanged. When full, a pop frees a slot visible as lsu_ready_o=1 the next cycle.
- rd=0: the entry is consumed or selected normally, but rf_we_o stays 0 that cycle. rf_waddr_o/rf_wdata_o are don't-care when rf_we_o=0 and must not write x0.
- No write cycle: rf_we_o=0; rf_waddr_o/rf_wdata_o hold previous values.
- Scoreboard:
  - pend_set_i sets bit pend_rd_i; bit 0 is never set.
  - A bit clears at the edge where a FIFO pop with that rd is registered into rf_*_o.
  - Set and clear of the same rd in one edge -> set wins, because it is a newer load.
  - ALU writes never touch pending_o; avoiding WAW is the issue stage's job.
- FIFO pointers wrap modulo DEPTH. Overflow is impossible by handshake; push while full is ignored (assertion in sim).

Test Plan:
- Reset, then one load x5 with LW, data 0xDEADBEEF, no ALU traffic -> rf_we_o=1, waddr=5, wdata=0xDEADBEEF exactly 2 cycles after accept; pending_o[5] set by pend_set, cleared the same edge.
- Extraction on word 0x80FF7F01: LB off=3 -> 0xFFFFFF80; LBU off=1 -> 0x0000007F; LH off=2 -> 0xFFFF80FF; LHU off=0 -> 0x00007F01.
- ALU valid 4 consecutive cycles while 3 loads offered with DEPTH=2 -> ALU writes in cycles 1-4; lsu_ready_o drops after 2 accepts; loads drain afterwards in issue order with no loss.
- Load and ALU both targeting x0 -> rf_we_o stays 0; FIFO still drains, count returns to 0.
- pend_set x7 on the same edge the previous x7 load writes back -> pending_o[7] remains 1; clears only on the second x7 writeback.
- Assert rst_ni low mid-drain with 2 entries queued -> outputs 0 immediately; after release no stale write appears, pending_o=0, lsu_ready_o=1.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: merges the priority ALU result stream with buffered load results
// into the registered register-file write port and tracks outstanding loads per register.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            alu_valid_i,
    input  logic [4:0]      alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    input  logic            lsu_valid_i,
    output logic            lsu_ready_o,
    input  logic [4:0]      lsu_rd_i,
    input  logic [31:0]     lsu_data_i,
    input  logic [2:0]      lsu_funct3_i,
    input  logic [1:0]      lsu_byteoff_i,
    input  logic            pend_set_i,
    input  logic [4:0]      pend_rd_i,
    output logic [31:0]     pending_o,
    output logic            rf_we_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] fifo_data [DEPTH];
    logic [4:0]      fifo_rd   [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic [XLEN-1:0] head_data;
    logic [4:0]      head_rd;

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_value;

    logic [31:0]     set_mask;
    logic [31:0]     clr_mask;

    // Load extraction: byte lane from byteoff, half lane from byteoff[1] only.
    always_comb begin
        ld_byte = lsu_data_i[7:0];
        case (lsu_byteoff_i)
            2'd0:    ld_byte = lsu_data_i[7:0];
            2'd1:    ld_byte = lsu_data_i[15:8];
            2'd2:    ld_byte = lsu_data_i[23:16];
            default: ld_byte = lsu_data_i[31:24];
        endcase
        ld_half = lsu_byteoff_i[1] ? lsu_data_i[31:16] : lsu_data_i[15:0];
    end

    always_comb begin
        load_value = XLEN'(lsu_data_i);
        case (lsu_funct3_i)
            3'b000:  load_value = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  load_value = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  load_value = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  load_value = {{(XLEN-16){1'b0}}, ld_half};
            default: load_value = XLEN'(lsu_data_i);
        endcase
    end

    // Ready looks only at the registered count; a same-cycle pop does not help.
    assign lsu_ready_o = (count < DEPTH_C);
    assign fifo_empty  = (count == '0);
    assign push        = lsu_valid_i && lsu_ready_o;
    assign pop         = !alu_valid_i && !fifo_empty;
    assign head_data   = fifo_data[rd_ptr];
    assign head_rd     = fifo_rd[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wr_ptr] <= load_value;
            fifo_rd[wr_ptr]   <= lsu_rd_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Writes to x0 are selected and consumed, but never raise the write enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else if (alu_valid_i) begin
            rf_we_o    <= (alu_rd_i != 5'd0);
            rf_waddr_o <= alu_rd_i;
            rf_wdata_o <= alu_data_i;
        end else if (pop) begin
            rf_we_o    <= (head_rd != 5'd0);
            rf_waddr_o <= head_rd;
            rf_wdata_o <= head_data;
        end else begin
            rf_we_o    <= 1'b0;
        end
    end

    // A new pending mark beats a same-edge writeback of the older load to that register.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (pend_set_i) begin
            set_mask[pend_rd_i] = 1'b1;
        end
        set_mask[0] = 1'b0;
        if (pop) begin
            clr_mask[head_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_o <= '0;
        end else begin
            pending_o <= (pending_o & ~clr_mask) | set_mask;
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (count <= DEPTH_C);
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scoreboard queues for ALU and load writebacks
// plus per-scenario timing and scoreboard-bit checks.
module tb_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_data_i;
    logic [2:0]  lsu_funct3_i;
    logic [1:0]  lsu_byteoff_i;
    logic        pend_set_i;
    logic [4:0]  pend_rd_i;
    logic [31:0] pending_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t alu_q[$];
    wr_t load_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;
    logic alu_due;

    wb_stage #(.XLEN(32), .DEPTH(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i),
        .lsu_data_i(lsu_data_i), .lsu_funct3_i(lsu_funct3_i), .lsu_byteoff_i(lsu_byteoff_i),
        .pend_set_i(pend_set_i), .pend_rd_i(pend_rd_i), .pending_o(pending_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    // An ALU-valid cycle must show up as the ALU write one cycle later.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) alu_due <= 1'b0;
        else         alu_due <= alu_valid_i;
    end

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (alu_due) begin
                checks++;
                if (alu_q.size() == 0) begin
                    errors++;
                    $display("FAIL alu_sb: ALU write slot but no expected ALU result queued");
                end else begin
                    mon_e = alu_q.pop_front();
                    if (rf_we_o !== (mon_e.rd != 5'd0) ||
                        (mon_e.rd != 5'd0 && (rf_waddr_o !== mon_e.rd || rf_wdata_o !== mon_e.data))) begin
                        errors++;
                        $display("FAIL alu_sb: got we=%0b addr=%0d data=%h, expected we=%0b addr=%0d data=%h",
                                 rf_we_o, rf_waddr_o, rf_wdata_o, (mon_e.rd != 5'd0), mon_e.rd, mon_e.data);
                    end
                end
            end else if (rf_we_o === 1'b1) begin
                checks++;
                if (load_q.size() == 0) begin
                    errors++;
                    $display("FAIL load_sb: unexpected write addr=%0d data=%h, expected no write",
                             rf_waddr_o, rf_wdata_o);
                end else begin
                    mon_e = load_q.pop_front();
                    if (rf_waddr_o !== mon_e.rd || rf_wdata_o !== mon_e.data) begin
                        errors++;
                        $display("FAIL load_sb: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 rf_waddr_o, rf_wdata_o, mon_e.rd, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        alu_valid_i   = 1'b0;
        alu_rd_i      = '0;
        alu_data_i    = '0;
        lsu_valid_i   = 1'b0;
        lsu_rd_i      = '0;
        lsu_data_i    = '0;
        lsu_funct3_i  = 3'b010;
        lsu_byteoff_i = '0;
        pend_set_i    = 1'b0;
        pend_rd_i     = '0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        checks++;
        if (rf_we_o !== 1'b0 || rf_waddr_o !== 5'd0 || rf_wdata_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_wport: got we=%0b addr=%0d data=%h, expected 0/0/0", rf_we_o, rf_waddr_o, rf_wdata_o);
        end
        checks++;
        if (pending_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_pending: got %h, expected 0", pending_o);
        end
        checks++;
        if (lsu_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %0b, expected 1", lsu_ready_o);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_single_load();
        @(negedge clk_i);
        pend_set_i = 1'b1;
        pend_rd_i  = 5'd5;
        @(negedge clk_i);
        pend_set_i = 1'b0;
        checks++;
        if (pending_o[5] !== 1'b1) begin
            errors++;
            $display("FAIL single_pend_set: got pending[5]=%0b, expected 1", pending_o[5]);
        end
        checks++;
        if (lsu_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %0b, expected 1", lsu_ready_o);
        end
        lsu_valid_i   = 1'b1;
        lsu_rd_i      = 5'd5;
        lsu_data_i    = 32'hDEADBEEF;
        lsu_funct3_i  = 3'b010;
        lsu_byteoff_i = 2'd0;
        load_q.push_back({5'd5, 32'hDEADBEEF});
        @(negedge clk_i);
        lsu_valid_i = 1'b0;
        checks++;
        if (rf_we_o !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got we=%0b one cycle after accept, expected 0", rf_we_o);
        end
        @(negedge clk_i);
        checks++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd5 || rf_wdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_wb: got we=%0b addr=%0d data=%h, expected 1/5/deadbeef", rf_we_o, rf_waddr_o, rf_wdata_o);
        end
        checks++;
        if (pending_o[5] !== 1'b0) begin
            errors++;
            $display("FAIL single_pend_clr: got pending[5]=%0b, expected 0", pending_o[5]);
        end
    endtask

    task automatic test_extract();
        logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b011};
        logic [1:0]  off [6] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd0};
        logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'hFFFF80FF, 32'h80FF7F01};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            checks++;
            if (lsu_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL extract_ready: load %0d got ready=%0b, expected 1", i, lsu_ready_o);
            end
            lsu_valid_i   = 1'b1;
            lsu_rd_i      = 5'(i + 1);
            lsu_data_i    = 32'h80FF7F01;
            lsu_funct3_i  = f3[i];
            lsu_byteoff_i = off[i];
            load_q.push_back({5'(i + 1), exp[i]});
        end
        @(negedge clk_i);
        lsu_valid_i = 1'b0;
        for (int k = 0; k < 20 && load_q.size() != 0; k++) @(negedge clk_i);
        checks++;
        if (load_q.size() != 0) begin
            errors++;
            $display("FAIL extract_drain: got %0d loads still expected, expected 0", load_q.size());
        end
    endtask

    task automatic test_alu_priority();
        logic exp_ready [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic ready_seen = 1'b0;
        int   li = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (c > 0 && lsu_valid_i && ready_seen) begin
                load_q.push_back({lsu_rd_i, lsu_data_i});
                li++;
            end
            checks++;
            if (lsu_ready_o !== exp_ready[c]) begin
                errors++;
                $display("FAIL alu_prio_ready: cycle %0d got ready=%0b, expected %0b", c, lsu_ready_o, exp_ready[c]);
            end
            ready_seen = lsu_ready_o;
            if (c < 4) begin
                alu_valid_i = 1'b1;
                alu_rd_i    = 5'(10 + c);
                alu_data_i  = 32'hA0000000 + 32'(c);
                alu_q.push_back({5'(10 + c), 32'hA0000000 + 32'(c)});
            end else begin
                alu_valid_i = 1'b0;
            end
            lsu_valid_i   = (li < 3);
            lsu_rd_i      = 5'(20 + li);
            lsu_data_i    = 32'h11110000 + 32'(li);
            lsu_funct3_i  = 3'b010;
            lsu_byteoff_i = 2'd0;
        end
        lsu_valid_i = 1'b0;
        checks++;
        if (li != 3) begin
            errors++;
            $display("FAIL alu_prio_accepts: got %0d loads accepted, expected 3", li);
        end
        for (int k = 0; k < 20 && (load_q.size() != 0 || alu_q.size() != 0); k++) @(negedge clk_i);
        checks++;
        if (load_q.size() != 0 || alu_q.size() != 0) begin
            errors++;
            $display("FAIL alu_prio_drain: got %0d load / %0d alu writes missing, expected 0/0", load_q.size(), alu_q.size());
        end
    endtask

    task automatic test_x0();
        @(negedge clk_i);
        alu_valid_i  = 1'b1;
        alu_rd_i     = 5'd0;
        alu_data_i   = 32'h55555555;
        alu_q.push_back({5'd0, 32'h55555555});
        lsu_valid_i  = 1'b1;
        lsu_rd_i     = 5'd0;
        lsu_data_i   = 32'h12345678;
        lsu_funct3_i = 3'b010;
        @(negedge clk_i);
        alu_valid_i = 1'b0;
        lsu_data_i  = 32'h9ABCDEF0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            lsu_valid_i = 1'b0;
            checks++;
            if (rf_we_o !== 1'b0) begin
                errors++;
                $display("FAIL x0_we: cycle %0d got we=%0b addr=%0d, expected 0", k, rf_we_o, rf_waddr_o);
            end
        end
        checks++;
        if (lsu_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: got %0b, expected 1", lsu_ready_o);
        end
        lsu_valid_i = 1'b1;
        lsu_rd_i    = 5'd3;
        lsu_data_i  = 32'h00C0FFEE;
        load_q.push_back({5'd3, 32'h00C0FFEE});
        @(negedge clk_i);
        lsu_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd3 || rf_wdata_o !== 32'h00C0FFEE) begin
            errors++;
            $display("FAIL x0_followup: got we=%0b addr=%0d data=%h, expected 1/3/00c0ffee", rf_we_o, rf_waddr_o, rf_wdata_o);
        end
    endtask

    task automatic test_pending_race();
        @(negedge clk_i);
        pend_set_i = 1'b1;
        pend_rd_i  = 5'd7;
        @(negedge clk_i);
        pend_set_i   = 1'b0;
        lsu_valid_i  = 1'b1;
        lsu_rd_i     = 5'd7;
        lsu_data_i   = 32'h00000077;
        lsu_funct3_i = 3'b010;
        load_q.push_back({5'd7, 32'h00000077});
        @(negedge clk_i);
        lsu_valid_i = 1'b0;
        pend_set_i  = 1'b1;
        pend_rd_i   = 5'd7;
        @(negedge clk_i);
        pend_set_i = 1'b0;
        checks++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd7 || pending_o[7] !== 1'b1) begin
            errors++;
            $display("FAIL race_set_wins: got we=%0b addr=%0d pending[7]=%0b, expected 1/7/1", rf_we_o, rf_waddr_o, pending_o[7]);
        end
        alu_valid_i = 1'b1;
        alu_rd_i    = 5'd7;
        alu_data_i  = 32'h000000A7;
        alu_q.push_back({5'd7, 32'h000000A7});
        @(negedge clk_i);
        alu_valid_i = 1'b0;
        pend_set_i  = 1'b1;
        pend_rd_i   = 5'd0;
        checks++;
        if (pending_o[7] !== 1'b1) begin
            errors++;
            $display("FAIL race_alu_no_clear: got pending[7]=%0b, expected 1", pending_o[7]);
        end
        @(negedge clk_i);
        pend_set_i = 1'b0;
        checks++;
        if (pending_o !== 32'h00000080) begin
            errors++;
            $display("FAIL race_x0_mark: got pending=%h, expected 00000080", pending_o);
        end
        lsu_valid_i = 1'b1;
        lsu_rd_i    = 5'd7;
        lsu_data_i  = 32'h00000078;
        load_q.push_back({5'd7, 32'h00000078});
        @(negedge clk_i);
        lsu_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (rf_we_o !== 1'b1 || rf_wdata_o !== 32'h00000078 || pending_o !== 32'd0) begin
            errors++;
            $display("FAIL race_second_clear: got we=%0b data=%h pending=%h, expected 1/00000078/00000000", rf_we_o, rf_wdata_o, pending_o);
        end
    endtask

    task automatic test_reset_mid_drain();
        @(negedge clk_i);
        pend_set_i   = 1'b1;
        pend_rd_i    = 5'd9;
        alu_valid_i  = 1'b1;
        alu_rd_i     = 5'd11;
        alu_data_i   = 32'hB0000011;
        alu_q.push_back({5'd11, 32'hB0000011});
        lsu_valid_i  = 1'b1;
        lsu_rd_i     = 5'd12;
        lsu_data_i   = 32'hC0000012;
        lsu_funct3_i = 3'b010;
        load_q.push_back({5'd12, 32'hC0000012});
        @(negedge clk_i);
        pend_set_i = 1'b0;
        alu_rd_i   = 5'd13;
        alu_data_i = 32'hB0000013;
        alu_q.push_back({5'd13, 32'hB0000013});
        lsu_rd_i   = 5'd14;
        lsu_data_i = 32'hC0000014;
        load_q.push_back({5'd14, 32'hC0000014});
        @(negedge clk_i);
        alu_rd_i    = 5'd15;
        alu_data_i  = 32'hB0000015;
        alu_q.push_back({5'd15, 32'hB0000015});
        lsu_valid_i = 1'b0;
        checks++;
        if (lsu_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_full: got ready=%0b with two loads queued, expected 0", lsu_ready_o);
        end
        @(negedge clk_i);
        alu_valid_i = 1'b0;
        checks++;
        if (rf_we_o !== 1'b1 || pending_o[9] !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got we=%0b pending[9]=%0b, expected 1/1", rf_we_o, pending_o[9]);
        end
        #1 rst_ni = 1'b0;
        #1;
        load_q.delete();
        alu_q.delete();
        checks++;
        if (rf_we_o !== 1'b0 || rf_waddr_o !== 5'd0 || rf_wdata_o !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_wport: got we=%0b addr=%0d data=%h, expected 0/0/0", rf_we_o, rf_waddr_o, rf_wdata_o);
        end
        checks++;
        if (pending_o !== 32'd0 || lsu_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_state: got pending=%h ready=%0b, expected 0/1", pending_o, lsu_ready_o);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            checks++;
            if (rf_we_o !== 1'b0) begin
                errors++;
                $display("FAIL mid_stale: cycle %0d got we=%0b addr=%0d, expected 0", k, rf_we_o, rf_waddr_o);
            end
        end
        checks++;
        if (pending_o !== 32'd0 || lsu_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_after: got pending=%h ready=%0b, expected 0/1", pending_o, lsu_ready_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_load();
        test_extract();
        test_alu_priority();
        test_x0();
        test_pending_race();
        test_reset_mid_drain();
        repeat (2) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
